// File: rtl/bcd_down_counter_if.sv
// Control/data bundle for the two-digit BCD down counter.
// The bench drives through master; the counter attaches to slave.
interface bcd_down_counter_if;
  logic       en;
  logic       load;
  logic [7:0] d_in;
  logic [7:0] Q_out;
  logic       zero;
  logic       borrow;
  logic       load_err;

  modport master (
    output en, load, d_in,
    input  Q_out, zero, borrow, load_err
  );

  modport slave (
    input  en, load, d_in,
    output Q_out, zero, borrow, load_err
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with parallel load, load validation and a wrap/borrow pulse.
// Edge priority: reset > load > en > hold.
module bcd_down_counter #(
  parameter bit STOP_AT_ZERO = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_asyn,
  bcd_down_counter_if.slave         bus
);

  logic [7:0] cnt_q,      cnt_d;
  logic       borrow_q,   borrow_d;
  logic       load_err_q, load_err_d;
  logic       load_ok;

  assign load_ok = (bus.d_in[7:4] <= 4'd9) && (bus.d_in[3:0] <= 4'd9);

  always_comb begin
    cnt_d      = cnt_q;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      // A rejected load still claims the cycle, so en is ignored either way.
      if (load_ok) cnt_d      = bus.d_in;
      else         load_err_d = 1'b1;
    end else if (bus.en) begin
      if (cnt_q[3:0] != 4'd0) begin
        cnt_d[3:0] = cnt_q[3:0] - 4'd1;
      end else if (cnt_q[7:4] != 4'd0) begin
        cnt_d = {cnt_q[7:4] - 4'd1, 4'd9};
      end else if (!STOP_AT_ZERO) begin
        cnt_d    = 8'h99;
        borrow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_asyn) begin
      cnt_q      <= 8'h99;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.Q_out    = cnt_q;
  assign bus.zero     = (cnt_q == 8'h00);
  assign bus.borrow   = borrow_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: wrapping and stop-at-zero instances.
module tb_bcd_down_counter;

  logic clk = 1'b0;
  logic rst0, rst1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  bcd_down_counter_if bus0 ();
  bcd_down_counter_if bus1 ();

  bcd_down_counter #(.STOP_AT_ZERO(1'b0)) dut0 (.clk(clk), .rst_asyn(rst0), .bus(bus0));
  bcd_down_counter #(.STOP_AT_ZERO(1'b1)) dut1 (.clk(clk), .rst_asyn(rst1), .bus(bus1));

  typedef struct {
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] d_in;
    logic [7:0] exp_q;
    logic       exp_zero;
    logic       exp_borrow;
    logic       exp_lerr;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc0(input logic r, input logic e, input logic l, input logic [7:0] d);
    @(negedge clk);
    rst0 = r; bus0.en = e; bus0.load = l; bus0.d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input logic r, input logic e, input logic l, input logic [7:0] d);
    @(negedge clk);
    rst1 = r; bus1.en = e; bus1.load = l; bus1.d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check0(input string tag, input logic [7:0] q, input logic z,
                        input logic b, input logic le);
    check({tag, ".q"},      bus0.Q_out,           q);
    check({tag, ".zero"},   {7'd0, bus0.zero},     {7'd0, z});
    check({tag, ".borrow"}, {7'd0, bus0.borrow},   {7'd0, b});
    check({tag, ".lerr"},   {7'd0, bus0.load_err}, {7'd0, le});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    logic [7:0] exp_bcd;
    logic       wrapped;

    rst0 = 1'b1; rst1 = 1'b1;
    bus0.en = 1'b0; bus0.load = 1'b0; bus0.d_in = '0;
    bus1.en = 1'b0; bus1.load = 1'b0; bus1.d_in = '0;

    //          rst   en    load  d_in   q      zero  borrow lerr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h33, 8'h09, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h57, 8'h57, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h56, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h5A, 8'h56, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'hA3, 8'h56, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h43, 8'h43, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 8'h12, 8'h99, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 8'h9F, 8'h00, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 20; i++) begin
      cyc0(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].d_in);
      check0($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_zero,
             vecs[i].exp_borrow, vecs[i].exp_lerr);
    end

    // Full 100-cycle countdown from reset, modelled in plain decimal.
    cyc0(1'b1, 1'b0, 1'b0, 8'h00);
    check0("rst99", 8'h99, 1'b0, 1'b0, 1'b0);
    v = 99;
    for (int i = 1; i <= 100; i++) begin
      wrapped = (v == 0);
      v = wrapped ? 99 : v - 1;
      exp_bcd = 8'((v / 10) * 16 + (v % 10));
      cyc0(1'b0, 1'b1, 1'b0, 8'h00);
      check0($sformatf("run%0d", i), exp_bcd, (v == 0), wrapped, 1'b0);
    end

    // Reset glitch between edges must not disturb the count.
    cyc0(1'b0, 1'b0, 1'b1, 8'h43);
    check0("pre_glitch", 8'h43, 1'b0, 1'b0, 1'b0);
    #1 rst0 = 1'b1;
    #1 rst0 = 1'b0;
    cyc0(1'b0, 1'b0, 1'b0, 8'h00);
    check0("post_glitch", 8'h43, 1'b0, 1'b0, 1'b0);
    cyc0(1'b1, 1'b1, 1'b1, 8'h12);
    check0("rst_mid", 8'h99, 1'b0, 1'b0, 1'b0);

    // Stop-at-zero instance.
    cyc1(1'b1, 1'b1, 1'b0, 8'h00);
    check("saz_rst", bus1.Q_out, 8'h99);
    cyc1(1'b0, 1'b0, 1'b1, 8'h02);
    check("saz_load", bus1.Q_out, 8'h02);
    for (int i = 0; i < 5; i++) begin
      cyc1(1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("saz_q%0d", i), bus1.Q_out, (i == 0) ? 8'h01 : 8'h00);
      check($sformatf("saz_zero%0d", i), {7'd0, bus1.zero}, (i == 0) ? 8'h00 : 8'h01);
      check($sformatf("saz_borrow%0d", i), {7'd0, bus1.borrow}, 8'h00);
    end
    cyc1(1'b0, 1'b1, 1'b1, 8'hA3);
    check("saz_lerr", {7'd0, bus1.load_err}, 8'h01);
    check("saz_lerr_q", bus1.Q_out, 8'h00);
    cyc1(1'b0, 1'b0, 1'b0, 8'h00);
    check("saz_lerr_clr", {7'd0, bus1.load_err}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
